// File: rtl/shift_add_multiplier_pkg.sv
// Shared ALU package for the sequential shift-add multiplier.
// Holds the control FSM encoding and the operand/iteration constants.
package shift_add_multiplier_pkg;

    localparam int MULT_WIDTH = 16;
    localparam int MULT_ITER  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// 16-bit ripple-carry adder, the multiplier's only arithmetic element.
// The carry ripples bit by bit through a local variable, least significant bit first.
module shift_add_multiplier_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    always_comb begin
        logic c;
        c   = carry_in;
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = in1[i] ^ in2[i] ^ c;
            c      = (in1[i] & in2[i]) | (c & (in1[i] ^ in2[i]));
        end
        carry_out = c;
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned 16x16 -> 32 multiplier: one conditional add plus a right shift per cycle.
// Fixed 16-iteration latency with a start/busy/done handshake toward the ALU control FSM.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MULT_ITER - 1);

    mult_state_t        r_state;
    mult_state_t        w_stateNext;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_p;
    logic [2*WIDTH-1:0] r_product;

    logic               w_accept;
    logic               w_lastIter;
    logic [WIDTH-1:0]   w_sum;
    logic               w_carry;
    logic [2*WIDTH-1:0] w_pNext;

    shift_add_multiplier_adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .in1      (r_p[2*WIDTH-1:WIDTH]),
        .in2      (r_a),
        .carry_in (1'b0),
        .sum      (w_sum),
        .carry_out(w_carry)
    );

    // The add's carry-out lands in the top bit, so the partial product can never overflow.
    always_comb begin
        w_pNext = {1'b0, r_p[2*WIDTH-1:1]};
        if (r_p[0]) begin
            w_pNext = {w_carry, w_sum, r_p[WIDTH-1:1]};
        end
    end

    always_comb begin
        w_accept   = start && ((r_state == IDLE) || (r_state == DONE));
        w_lastIter = (r_state == RUN) && (r_count == LAST_COUNT);
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    w_stateNext = start ? RUN : IDLE;
            RUN:     w_stateNext = (r_count == LAST_COUNT) ? DONE : RUN;
            DONE:    w_stateNext = start ? RUN : IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Starts are only honoured when ready, so a start pulse mid-run leaves A/P/count untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a       <= '0;
            r_p       <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_a     <= in1;
            r_p     <= {{WIDTH{1'b0}}, in2};
            r_count <= '0;
        end else if (r_state == RUN) begin
            r_p     <= w_pNext;
            r_count <= r_count + CNT_W'(1);
            if (w_lastIter) begin
                r_product <= w_pNext;
            end
        end
    end

    assign busy    = (r_state == RUN);
    assign done    = (r_state == DONE);
    assign product = r_product;

endmodule
